// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial compare unit.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_LT  = 3'b001,
        OP_LE  = 3'b010,
        OP_NE  = 3'b011,
        OP_LTU = 3'b100,
        OP_LEU = 3'b101
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } cmp_state_e;

    // Bit positions inside the {z, n, v, c} flag vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/cmp_slice.sv
// One SLICE-bit piece of a - b, computed as a + ~b + cin.
module cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout,
    output logic             o_is_zero
);

    logic [SLICE:0] w_full;

    assign w_full    = {1'b0, i_a} + {1'b0, ~i_b} + (SLICE+1)'(i_cin);
    assign o_sum     = w_full[SLICE-1:0];
    assign o_cout    = w_full[SLICE];
    assign o_is_zero = (w_full[SLICE-1:0] == '0);

endmodule

// File: rtl/cmp_unit.sv
// Serial set-on-compare unit: subtracts SLICE bits per cycle, then resolves the op.
// Define CMP_UNSIGNED_EN to enable the LTU/LEU ops; otherwise they return 0.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic [3:0]       flags
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_width
            $error("cmp_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    function automatic logic resolve(input logic [2:0] i_op, input logic [3:0] i_f);
        logic w_lt;
        logic w_res;
        w_lt = i_f[FLAG_N] ^ i_f[FLAG_V];
        case (cmp_op_e'(i_op))
            OP_EQ:   w_res = i_f[FLAG_Z];
            OP_LT:   w_res = w_lt;
            OP_LE:   w_res = w_lt | i_f[FLAG_Z];
            OP_NE:   w_res = ~i_f[FLAG_Z];
`ifdef CMP_UNSIGNED_EN
            OP_LTU:  w_res = ~i_f[FLAG_C];
            OP_LEU:  w_res = ~i_f[FLAG_C] | i_f[FLAG_Z];
`endif
            default: w_res = 1'b0;
        endcase
        return w_res;
    endfunction

    cmp_state_e       r_state;
    cmp_state_e       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_carry;
    logic             r_zacc;
    logic [CNT_W-1:0] r_count;
    logic             r_res;
    logic [3:0]       r_flags;

    logic [SLICE-1:0] w_a_sl [NSLICE];
    logic [SLICE-1:0] w_b_sl [NSLICE];
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_zero;
    logic [3:0]       w_flags_new;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_sl
        assign w_a_sl[gi] = r_a[gi*SLICE +: SLICE];
        assign w_b_sl[gi] = r_b[gi*SLICE +: SLICE];
    end

    // Single adder shared across cycles; the counter selects the active slice
    cmp_slice #(.SLICE(SLICE)) u_slice (
        .i_a       (w_a_sl[r_count]),
        .i_b       (w_b_sl[r_count]),
        .i_cin     (r_carry),
        .o_sum     (w_sum),
        .o_cout    (w_cout),
        .o_is_zero (w_zero)
    );

    assign w_flags_new[FLAG_Z] = r_zacc & w_zero;
    assign w_flags_new[FLAG_N] = w_sum[SLICE-1];
    assign w_flags_new[FLAG_V] = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_sum[SLICE-1] ^ r_a[WIDTH-1]);
    assign w_flags_new[FLAG_C] = w_cout;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_next = BUSY;
            BUSY:    if (r_count == LAST) w_next = DONE;
            DONE:    if (out_ready)       w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    // Operands are only captured on acceptance, so later input changes are ignored
    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry <= 1'b1;
            r_zacc  <= 1'b1;
            r_count <= '0;
            r_res   <= 1'b0;
            r_flags <= 4'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_carry <= 1'b1;
                        r_zacc  <= 1'b1;
                        r_count <= '0;
                    end
                end
                BUSY: begin
                    r_carry <= w_cout;
                    r_zacc  <= r_zacc & w_zero;
                    if (r_count == LAST) begin
                        r_flags <= w_flags_new;
                        r_res   <= resolve(r_op, w_flags_new);
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = OUT_W'(r_res);
    assign flags     = r_flags;

endmodule

// File: tb/tb_cmp_unit.sv
// Directed scoreboard bench for cmp_unit (WIDTH=32, SLICE=8).
module tb_cmp_unit;
    import cmp_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int OUT_W  = 32;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] result;
    logic [3:0]       flags;

    int total = 0;
    int bad   = 0;
    logic [35:0] sb_q[$];

    cmp_unit #(.WIDTH(WIDTH), .SLICE(SLICE), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Full-width reference subtraction; returns {result, z, n, v, c}
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
        logic [32:0] d;
        logic z, n, v, c, r;
        d = {1'b0, x} + {1'b0, ~y} + 33'd1;
        c = d[32];
        z = (d[31:0] == 32'd0);
        n = d[31];
        v = (x[31] != y[31]) && (d[31] != x[31]);
        case (o)
            3'd0: r = z;
            3'd1: r = n ^ v;
            3'd2: r = (n ^ v) | z;
            3'd3: r = ~z;
`ifdef CMP_UNSIGNED_EN
            3'd4: r = ~c;
            3'd5: r = ~c | z;
`endif
            default: r = 1'b0;
        endcase
        return {31'd0, r, z, n, v, c};
    endfunction

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after acceptance
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
        chk("in_ready_idle", 36'(in_ready), 36'd1);
        a = x; b = y; op = o; in_valid = 1'b1;
        sb_q.push_back(model(x, y, o));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        chk("in_ready_busy", 36'(in_ready), 36'd0);
    endtask

    task automatic wait_out(input string tag);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 36'(cyc), 36'(NSLICE));
    endtask

    task automatic compare(input string tag);
        logic [35:0] exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 36'hF_FFFF_FFFF;
        chk({tag, "_result_flags"}, {result, flags}, exp);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_retired"}, 36'({out_valid, in_ready}), 36'b01);
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o, input string tag);
        send(x, y, o);
        wait_out(tag);
        compare(tag);
        retire(tag);
    endtask

    initial begin
        logic [35:0] held;
        logic        seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 36'(out_valid), 36'd0);
        chk("reset_result", 36'(result), 36'd0);
        chk("reset_flags", 36'(flags), 36'd0);
        chk("reset_in_ready", 36'(in_ready), 36'd1);
        reset = 1'b0;
        @(negedge clk);

        // EQ match with explicit flag constants
        send(32'd5, 32'd5, 3'b000);
        wait_out("eq");
        chk("eq_const", 36'({result, flags}), {32'd1, 4'b1001});
        compare("eq");
        retire("eq");

        run(32'hFFFF_FFFD, 32'd2, 3'b001, "lt_signed");
        run(32'hFFFF_FFFD, 32'd2, 3'b010, "le_signed");
        run(32'hFFFF_FFFD, 32'd2, 3'b100, "ltu");

        // Signed overflow: 0x80000000 - 1
        send(32'h8000_0000, 32'd1, 3'b001);
        wait_out("ovf");
        chk("ovf_const", 36'({result, flags}), {32'd1, 4'b0011});
        compare("ovf");
        retire("ovf");

        // Unsigned below, flag c must be clear regardless of build
        send(32'd1, 32'd2, 3'b100);
        wait_out("ltu_small");
        chk("ltu_small_c", 36'(flags[FLAG_C]), 36'd0);
        compare("ltu_small");
        retire("ltu_small");
        run(32'd2, 32'd2, 3'b101, "leu_eq");
        run(32'd9, 32'd3, 3'b110, "op110");
        run(32'd3, 32'd3, 3'b111, "op111");

        // Backpressure, then retire with a simultaneous new request
        send(32'd10, 32'd3, 3'b011);
        wait_out("bp");
        held = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {result, flags}, held);
            chk("bp_ctrl", 36'({out_valid, in_ready}), 36'b10);
        end
        compare("bp");
        a = 32'd7; b = 32'd7; op = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("simul_not_accepted", 36'({out_valid, in_ready}), 36'b01);
        sb_q.push_back(model(32'd7, 32'd7, 3'b000));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("simul_accepted_next", 36'(in_ready), 36'd0);
        wait_out("simul");
        compare("simul");
        retire("simul");

        // Reset after two busy cycles aborts the operation
        send(32'h1234_5678, 32'h0000_0001, 3'b001);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(sb_q.pop_back());
        chk("abort_outputs", {result, flags}, 36'd0);
        chk("abort_ctrl", 36'({out_valid, in_ready}), 36'b01);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 36'(seen), 36'd0);
        run(32'd7, 32'd7, 3'b000, "after_abort");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i == 3) ? x : $urandom;
            run(x, y, 3'(i), "rand");
        end

        chk("sb_empty", 36'(sb_q.size()), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
